// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops 4-7).
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV     = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  function automatic logic is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even encodings are the signed flavours of each op pair.
  function automatic logic is_signed(input op_t op);
    return ~op[0];
  endfunction

  function automatic logic is_madd(input op_t op);
    return op[2];
  endfunction

  function automatic logic is_msub(input op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per cycle; done is high during the cycle of the final
// iteration so the results are valid in the registers on the following cycle.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = (trial >= {1'b0, dvs_q});
  end

  assign done = active && (cnt == CW'(1));
  assign quo  = quo_q;
  assign rem  = rem_q;

  // Load operands on go, then run WIDTH shift/subtract iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (go) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt    <= CW'(WIDTH);
      active <= 1'b1;
    end else if (active) begin
      rem_q <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], ge};
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Optional feature macro: MDU_MADD_EN -- ops 4-7 accumulate into {HI,LO};
// when undefined those ops are no-ops.
//
// Handshake: start is a one-cycle launch pulse that is accepted only when
// busy is low (start while busy is ignored). busy rises the cycle after an
// accepted start and falls on the edge that writes HI/LO. A direct write (we)
// is accepted only when idle and not accompanied by start.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             we,
  input  logic             HiLo,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  state_t             state, state_nxt;
  op_t                op_in;
  logic               mul_op, div_op, div_go, div_done, sgn;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_nxt, prod_q, mul_res;
  logic [WIDTH-1:0]   mag1, mag2, quo, rem, quo_s, rem_s, d1_q;
  logic               qneg_q, rneg_q, dz_q;

  assign op_in  = op_t'(op);
  assign div_op = is_div(op_in);
  assign sgn    = is_signed(op_in);
`ifdef MDU_MADD_EN
  assign mul_op = !div_op;
`else
  assign mul_op = (op_in == OP_MULT) || (op_in == OP_MULTU);
`endif
  assign div_go    = (state == S_IDLE) && start && div_op;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Operand extension, full-width product and divider magnitudes.
  always_comb begin
    a_ext    = sgn ? {{WIDTH{D1[WIDTH-1]}}, D1} : {{WIDTH{1'b0}}, D1};
    b_ext    = sgn ? {{WIDTH{D2[WIDTH-1]}}, D2} : {{WIDTH{1'b0}}, D2};
    prod_nxt = a_ext * b_ext;
    mag1     = (sgn && D1[WIDTH-1]) ? -D1 : D1;
    mag2     = (sgn && D2[WIDTH-1]) ? -D2 : D2;
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend (mag1),
    .divisor  (mag2),
    .done     (div_done),
    .quo      (quo),
    .rem      (rem)
  );

  // Sign correction of the magnitude results; MIN / -1 wraps naturally.
  always_comb begin
    quo_s = qneg_q ? -quo : quo;
    rem_s = rneg_q ? -rem : rem;
  end

`ifdef MDU_MADD_EN
  op_t op_q;

  // Remember which multiply flavour is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) op_q <= OP_MULT;
    else if ((state == S_IDLE) && start && mul_op) op_q <= op_in;
  end

  // Accumulate against the held HI/LO, modulo 2^(2*WIDTH).
  always_comb begin
    mul_res = prod_q;
    if (is_madd(op_q)) mul_res = is_msub(op_q) ? ({HI, LO} - prod_q) : ({HI, LO} + prod_q);
  end
`else
  assign mul_res = prod_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && div_op)      state_nxt = S_DIV;
        else if (start && mul_op) state_nxt = S_MUL;
      end
      S_MUL:     if (cnt == '0) state_nxt = S_IDLE;
      S_DIV:     if (div_done)  state_nxt = S_DIV_FIX;
      S_DIV_FIX: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture at launch, HI/LO writes at completion or direct write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI     <= '0;
      LO     <= '0;
      cnt    <= '0;
      prod_q <= '0;
      d1_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mul_op) begin
              prod_q <= prod_nxt;
              cnt    <= CW'(MUL_CYCLES - 1);
            end
            if (div_op) begin
              d1_q   <= D1;
              qneg_q <= sgn & (D1[WIDTH-1] ^ D2[WIDTH-1]);
              rneg_q <= sgn & D1[WIDTH-1];
              dz_q   <= (D2 == '0);
            end
          end else if (we) begin
            if (HiLo) HI <= D1;
            else      LO <= D1;
          end
        end
        S_MUL: begin
          if (cnt == '0) {HI, LO} <= mul_res;
          else           cnt <= cnt - CW'(1);
        end
        S_DIV_FIX: begin
          if (dz_q) begin
            HI <= d1_q;
            LO <= '1;
          end else begin
            HI <= rem_s;
            LO <= quo_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5).
// Honours MDU_MADD_EN: expectations for ops 4-7 follow the same macro.
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int MC = 5;

  logic          clk, reset, start, we, HiLo, busy;
  logic [2:0]    op;
  logic [W-1:0]  D1, D2, HI, LO;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [W-1:0] hi_m, lo_m;

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .D1(D1), .D2(D2),
    .we(we), .HiLo(HiLo), .busy(busy), .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {HI,LO} after an op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p, q, r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[0]) p = {32'b0, a} * {32'b0, b};
    else      p = sa * sb;
    case (o)
      3'd0, 3'd1: return p;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = {32'b0, a / b};
        r = {32'b0, a % b};
        return {r[31:0], q[31:0]};
      end
      3'd4, 3'd5: return acc + p;
      default:    return acc - p;
    endcase
  endfunction

  function automatic bit op_active(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return 1'b1 | o[0];
`else
    return (o < 3'd4);
`endif
  endfunction

  // Drive one op launch (optionally with we in the same cycle); leaves start low.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic w);
    @(negedge clk);
    if (op_active(o)) exp_q.push_back(model(o, a, b, {hi_m, lo_m}));
    start = 1'b1; op = o; D1 = a; D2 = b; we = w; HiLo = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    D1 = $urandom; D2 = $urandom;
  endtask

  // Wait for busy to fall, check its length and the scoreboard result.
  task automatic finish(input string tag, input int exp_n);
    int n;
    logic [63:0] e;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(n), 64'(exp_n));
    e = exp_q.pop_front();
    check(tag, {HI, LO}, e);
    {hi_m, lo_m} = e;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    launch(o, a, b, 1'b0);
    if (!op_active(o)) begin
      check({tag, "_noop_busy"}, 64'(busy), 64'(0));
      check({tag, "_noop_hilo"}, {HI, LO}, {hi_m, lo_m});
      return;
    end
    check({tag, "_hold"}, {HI, LO}, {hi_m, lo_m});
    finish(tag, (o == 3'd2 || o == 3'd3) ? W + 1 : MC);
  endtask

  task automatic write_hilo(input logic hl, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; HiLo = hl; D1 = d;
    @(negedge clk);
    we = 1'b0;
    if (hl) hi_m = d; else lo_m = d;
    check(hl ? "we_hi" : "we_lo", {HI, LO}, {hi_m, lo_m});
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(0, allow_zero ? 4 : 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(1, 300));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    reset = 1'b0; start = 1'b0; we = 1'b0; HiLo = 1'b0; op = 3'd0; D1 = '0; D2 = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hilo", {HI, LO}, 64'(0));
    check("reset_state", 64'(dbg_state), 64'(mdu_pkg::S_IDLE));
    reset = 1'b1;

    // Directed cases.
    run_op("multu_100x100", 3'd1, 32'd100, 32'd100);
    check("multu_100x100_lo", 64'(LO), 64'd10000);
    run_op("mult_m1xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_m1xm1_val", {HI, LO}, 64'd1);
    run_op("multu_maxxmax", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_maxxmax_val", {HI, LO}, {32'hFFFF_FFFE, 32'h1});
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    check("divu_100_7_val", {HI, LO}, {32'd2, 32'd14});
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_val", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_5_0", 3'd2, 32'd5, 32'd0);
    check("div_5_0_val", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_val", {HI, LO}, {32'd0, 32'h8000_0000});

    // Direct writes.
    write_hilo(1'b1, 32'h1234);
    write_hilo(1'b0, 32'hCAFE_0001);

    // start together with we: start wins, write dropped.
    launch(3'd1, 32'd7, 32'd9, 1'b1);
    finish("start_we_same", MC);

    // start / we while busy are ignored.
    launch(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd1; D1 = 32'd9; D2 = 32'd9; we = 1'b1; HiLo = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    finish("busy_ignore", W + 1 - 4);
    repeat (8) @(negedge clk);
    check("busy_ignore_after", {HI, LO}, {hi_m, lo_m});
    check("busy_ignore_idle", 64'(busy), 64'(0));

    // Reset in the middle of a divide aborts it immediately.
    launch(3'd3, 32'd12345, 32'd11, 1'b0);
    repeat (9) @(negedge clk);
    check("midop_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("midop_reset_busy", 64'(busy), 64'(0));
    check("midop_reset_hilo", {HI, LO}, 64'(0));
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    check("midop_no_result", {HI, LO}, 64'(0));

    // Accumulate ops, or their no-op behaviour.
    run_op("acc_multu", 3'd1, 32'd3, 32'd4);
    run_op("acc_maddu", 3'd5, 32'd5, 32'd6);
`ifdef MDU_MADD_EN
    check("acc_maddu_lo", 64'(LO), 64'd42);
    run_op("acc_msubu", 3'd7, 32'd1, 32'd43);
    check("acc_msubu_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    run_op("op4_noop", 3'd4, 32'd5, 32'd6);
    check("op4_noop_lo", 64'(LO), 64'd12);
`endif

    // Randomized ops against the model.
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, pick(1'b0), pick(1'b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
